// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Holds the default ratio, the minimum legal ratio and the high-time helper.
package clkdiv_pkg;

  localparam int CLKDIV_W       = 8;
  localparam int CLKDIV_DEF_DIV = 4;
  localparam int CLKDIV_MIN_DIV = 2;

  // High phase length for ratio n: ceil(n/2), so odd ratios get the extra cycle high.
  function automatic int unsigned clkdiv_high_cnt(input int unsigned n);
    return n - (n / 2);
  endfunction

endpackage

// File: rtl/clkdiv_ratio_ctrl.sv
// Ratio reload control: valid/ready capture of a new ratio, rejection of
// ratios below the minimum, and application of the pending ratio at a period boundary.
module clkdiv_ratio_ctrl
  import clkdiv_pkg::*;
#(
  parameter int W       = CLKDIV_W,
  parameter int DEF_DIV = CLKDIV_DEF_DIV
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         cnt_last,
  input  logic [W-1:0] div_in,
  input  logic         div_valid,
  output logic         div_ready,
  output logic [W-1:0] div_cur,
  output logic         err
);

  logic [W-1:0] pend_reg;

  // div_ready low means pend_reg holds a ratio waiting for the next boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_reg  <= '0;
      div_ready <= 1'b1;
      div_cur   <= W'(DEF_DIV);
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      if (div_ready && div_valid) begin
        if (div_in >= W'(CLKDIV_MIN_DIV)) begin
          pend_reg  <= div_in;
          div_ready <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end else if (!div_ready && (!en || cnt_last)) begin
        div_cur   <= pend_reg;
        div_ready <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with registered clk_out and edge ticks.
// Optional fall_tick output is built when CLKDIV_FALL_TICK_EN is defined.
module clk_div_prog
  import clkdiv_pkg::*;
#(
  parameter int W       = CLKDIV_W,
  parameter int DEF_DIV = CLKDIV_DEF_DIV
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] div_in,
  input  logic         div_valid,
  output logic         div_ready,
  output logic         clk_out,
  output logic         rise_tick,
`ifdef CLKDIV_FALL_TICK_EN
  output logic         fall_tick,
`endif
  output logic [W-1:0] div_cur,
  output logic         err
);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;
  logic [W-1:0] high_cnt;
  logic         clk_out_next;
  logic         cnt_last;

  assign high_cnt = W'(clkdiv_high_cnt(32'(div_cur)));
  assign cnt_last = (cnt_reg == (div_cur - W'(1)));

  clkdiv_ratio_ctrl #(
    .W       (W),
    .DEF_DIV (DEF_DIV)
  ) u_ratio_ctrl (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cnt_last  (cnt_last),
    .div_in    (div_in),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .div_cur   (div_cur),
    .err       (err)
  );

  // clk_out is derived from the phase being left, so a ratio loaded at the
  // wrap only shapes the period that follows it.
  always_comb begin
    cnt_next     = '0;
    clk_out_next = 1'b0;
    if (en) begin
      cnt_next     = cnt_last ? '0 : cnt_reg + W'(1);
      clk_out_next = (cnt_reg < high_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
      clk_out <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      clk_out <= clk_out_next;
    end
  end

`ifdef CLKDIV_FALL_TICK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
    end else begin
      rise_tick <= clk_out_next & ~clk_out;
      fall_tick <= ~clk_out_next & clk_out;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise_tick <= 1'b0;
    end else begin
      rise_tick <= clk_out_next & ~clk_out;
    end
  end
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: default ratio, reload handshake, rejected
// ratios, back-to-back requests, enable gating and asynchronous reset.
module tb_clk_div_prog;
  import clkdiv_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         en;
  logic [W-1:0] div_in;
  logic         div_valid;
  logic         div_ready;
  logic         clk_out;
  logic         rise_tick;
`ifdef CLKDIV_FALL_TICK_EN
  logic         fall_tick;
`endif
  logic [W-1:0] div_cur;
  logic         err;

  int checks;
  int failures;

  clk_div_prog #(.W(W), .DEF_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .div_in    (div_in),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .clk_out   (clk_out),
    .rise_tick (rise_tick),
`ifdef CLKDIV_FALL_TICK_EN
    .fall_tick (fall_tick),
`endif
    .div_cur   (div_cur),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; en = 1'b0; div_in = '0; div_valid = 1'b0;
    #12;
    checks++;
    if ({clk_out, rise_tick, err, div_ready, div_cur} !== {1'b0, 1'b0, 1'b0, 1'b1, 8'd4}) begin
      failures++;
      $display("FAIL reset: got clk/rise/err/rdy/cur=%b/%b/%b/%b/%0d required 0/0/0/1/4",
               clk_out, rise_tick, err, div_ready, div_cur);
    end
    rst = 1'b1;
  endtask

  task automatic test_default;
    logic e_clk, e_rise;
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      e_clk  = (i % 4) < 2;
      e_rise = (i % 4) == 0;
      checks++;
      if ({clk_out, rise_tick, div_cur} !== {e_clk, e_rise, 8'd4}) begin
        failures++;
        $display("FAIL default step %0d: got clk/rise/cur=%b/%b/%0d required %b/%b/4",
                 i, clk_out, rise_tick, div_cur, e_clk, e_rise);
      end
`ifdef CLKDIV_FALL_TICK_EN
      checks++;
      if (fall_tick !== ((i % 4) == 2)) begin
        failures++;
        $display("FAIL default fall step %0d: got %b required %b", i, fall_tick, (i % 4) == 2);
      end
`endif
    end
    $display("default N=4 sequence done");
  endtask

  task automatic test_change;
    logic e_clk, e_rise;
    step();
    div_in = 8'd5; div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    checks++;
    if ({div_ready, div_cur, clk_out} !== {1'b0, 8'd4, 1'b1}) begin
      failures++;
      $display("FAIL change accept: got rdy/cur/clk=%b/%0d/%b required 0/4/1", div_ready, div_cur, clk_out);
    end
    step();
    checks++;
    if ({div_ready, div_cur, clk_out} !== {1'b0, 8'd4, 1'b0}) begin
      failures++;
      $display("FAIL change hold: got rdy/cur/clk=%b/%0d/%b required 0/4/0", div_ready, div_cur, clk_out);
    end
    step();
    checks++;
    if ({div_ready, div_cur, clk_out} !== {1'b1, 8'd5, 1'b0}) begin
      failures++;
      $display("FAIL change apply: got rdy/cur/clk=%b/%0d/%b required 1/5/0", div_ready, div_cur, clk_out);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      e_clk  = (i % 5) < 3;
      e_rise = (i % 5) == 0;
      checks++;
      if ({clk_out, rise_tick, div_cur} !== {e_clk, e_rise, 8'd5}) begin
        failures++;
        $display("FAIL n5 step %0d: got clk/rise/cur=%b/%b/%0d required %b/%b/5",
                 i, clk_out, rise_tick, div_cur, e_clk, e_rise);
      end
    end
    $display("ratio change 4->5 done");
  endtask

  task automatic test_err;
    logic e_err, e_clk;
    for (int k = 0; k < 5; k++) begin
      div_valid = (k == 0) || (k == 2);
      div_in    = (k == 0) ? 8'd1 : 8'd0;
      step();
      div_valid = 1'b0;
      e_err = (k == 0) || (k == 2);
      e_clk = k < 3;
      checks++;
      if ({err, div_ready, div_cur, clk_out} !== {e_err, 1'b1, 8'd5, e_clk}) begin
        failures++;
        $display("FAIL err step %0d: got err/rdy/cur/clk=%b/%b/%0d/%b required %b/1/5/%b",
                 k, err, div_ready, div_cur, clk_out, e_err, e_clk);
      end
    end
    $display("rejected ratios 1 and 0 done");
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] e_cur;
    logic         e_rdy, e_clk;
    for (int k = 0; k < 19; k++) begin
      div_valid = (k <= 5);
      div_in    = (k == 0) ? 8'd6 : 8'd8;
      step();
      e_cur = (k < 4) ? 8'd5 : (k < 10) ? 8'd6 : 8'd8;
      e_rdy = (k == 4) || (k >= 10);
      e_clk = (k < 5) ? (k < 3) : (k < 11) ? ((k - 5) < 3) : ((k - 11) < 4);
      checks++;
      if ({div_cur, div_ready, clk_out} !== {e_cur, e_rdy, e_clk}) begin
        failures++;
        $display("FAIL b2b step %0d: got cur/rdy/clk=%0d/%b/%b required %0d/%b/%b",
                 k, div_cur, div_ready, clk_out, e_cur, e_rdy, e_clk);
      end
    end
    div_valid = 1'b0;
    $display("back-to-back 6 then 8 done");
  endtask

  task automatic test_enable;
    step(); step();
    checks++;
    if (clk_out !== 1'b1) begin
      failures++;
      $display("FAIL en high phase: got clk=%b required 1", clk_out);
    end
    en = 1'b0;
    step();
    checks++;
    if ({clk_out, rise_tick} !== 2'b00) begin
      failures++;
      $display("FAIL en drop: got clk/rise=%b/%b required 0/0", clk_out, rise_tick);
    end
`ifdef CLKDIV_FALL_TICK_EN
    checks++;
    if (fall_tick !== 1'b1) begin
      failures++;
      $display("FAIL en drop fall: got %b required 1", fall_tick);
    end
`endif
    div_in = 8'd3; div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    checks++;
    if ({clk_out, div_ready, div_cur} !== {1'b0, 1'b0, 8'd8}) begin
      failures++;
      $display("FAIL en off accept: got clk/rdy/cur=%b/%b/%0d required 0/0/8", clk_out, div_ready, div_cur);
    end
    step();
    checks++;
    if ({clk_out, div_ready, div_cur} !== {1'b0, 1'b1, 8'd3}) begin
      failures++;
      $display("FAIL en off apply: got clk/rdy/cur=%b/%b/%0d required 0/1/3", clk_out, div_ready, div_cur);
    end
    en = 1'b1;
    step();
    checks++;
    if ({clk_out, rise_tick} !== 2'b11) begin
      failures++;
      $display("FAIL en restart: got clk/rise=%b/%b required 1/1", clk_out, rise_tick);
    end
    step();
    checks++;
    if ({clk_out, rise_tick} !== 2'b10) begin
      failures++;
      $display("FAIL en restart+1: got clk/rise=%b/%b required 1/0", clk_out, rise_tick);
    end
    step();
    checks++;
    if ({clk_out, rise_tick} !== 2'b00) begin
      failures++;
      $display("FAIL en restart+2: got clk/rise=%b/%b required 0/0", clk_out, rise_tick);
    end
    $display("enable gating done");
  endtask

  task automatic test_async_reset;
    logic e_clk, e_rise;
    step();
    div_in = 8'd7; div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    checks++;
    if ({clk_out, div_ready} !== 2'b10) begin
      failures++;
      $display("FAIL pre-reset: got clk/rdy=%b/%b required 1/0", clk_out, div_ready);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({clk_out, rise_tick, err, div_ready, div_cur} !== {1'b0, 1'b0, 1'b0, 1'b1, 8'd4}) begin
      failures++;
      $display("FAIL async reset: got clk/rise/err/rdy/cur=%b/%b/%b/%b/%0d required 0/0/0/1/4",
               clk_out, rise_tick, err, div_ready, div_cur);
    end
    #1 rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      e_clk  = (i % 4) < 2;
      e_rise = (i % 4) == 0;
      checks++;
      if ({clk_out, rise_tick, div_cur} !== {e_clk, e_rise, 8'd4}) begin
        failures++;
        $display("FAIL post-reset step %0d: got clk/rise/cur=%b/%b/%0d required %b/%b/4",
                 i, clk_out, rise_tick, div_cur, e_clk, e_rise);
      end
    end
    $display("async reset with pending ratio done");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_default();
    test_change();
    test_err();
    test_back_to_back();
    test_enable();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
